// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline port P has fixed priority, debug/loader port D
// gets a guaranteed slot after STARVE_LIMIT lost cycles and may lock the memory.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       p_req,
  input  logic       p_we,
  input  logic [7:0] p_addr,
  input  logic [7:0] p_wdata,
  output logic       p_gnt,
  output logic       p_rvalid,
  output logic       p_stall,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  input  logic       d_lock,
  output logic       d_gnt,
  output logic       d_rvalid,
  output logic [7:0] rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_rden,
  output logic       mem_wren,
  input  logic [7:0] mem_q
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          lock_own;
  logic          rd_p;
  logic          rd_d;
  logic          d_win;

  // D wins while it holds the lock, once starved long enough, or when P is idle.
  assign d_win   = d_req & (lock_own | (starve_cnt == LIMIT) | ~p_req);
  assign d_gnt   = d_win;
  assign p_gnt   = p_req & ~d_win & ~lock_own;
  assign p_stall = p_req & ~p_gnt;

  assign p_rvalid = rd_p;
  assign d_rvalid = rd_d;
  assign rdata    = mem_q;

  always_comb begin
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_rden  = 1'b0;
    mem_wren  = 1'b0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_rden  = ~d_we;
      mem_wren  = d_we;
    end else if (p_gnt) begin
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
      mem_rden  = ~p_we;
      mem_wren  = p_we;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      lock_own   <= 1'b0;
      rd_p       <= 1'b0;
      rd_d       <= 1'b0;
    end else begin
      if (d_req & ~d_gnt) begin
        if (starve_cnt != LIMIT)
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end

      // Lock is taken only by a granted access and held until d_lock falls.
      if (~d_lock)
        lock_own <= 1'b0;
      else if (d_gnt)
        lock_own <= 1'b1;

      rd_p <= p_gnt & ~p_we;
      rd_d <= d_gnt & ~d_we;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_dmem_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       p_req, p_we;
  logic [7:0] p_addr, p_wdata;
  logic       p_gnt, p_rvalid, p_stall;
  logic       d_req, d_we, d_lock;
  logic [7:0] d_addr, d_wdata;
  logic       d_gnt, d_rvalid;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_q;
  logic       mem_rden, mem_wren;

  int vectors = 0;
  int errors  = 0;

  dmem_arbiter #(.STARVE_LIMIT(4), .CW(3)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_lock = 0;
  endtask

  // {p_gnt, d_gnt, p_stall, mem_rden, mem_wren, p_rvalid, d_rvalid}
  task automatic test_reset;
    logic [6:0] obs;
    idle_inputs();
    mem_q = 8'h00;
    reset = 1;
    #3;
    obs = {p_gnt, d_gnt, p_stall, mem_rden, mem_wren, p_rvalid, d_rvalid};
    vectors++;
    if (obs !== 7'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h want ctl=0000000 addr=00 wdata=00", obs, mem_addr, mem_wdata);
    end
    next_cycle();
    next_cycle();
    reset = 0;
    next_cycle();
  endtask

  task automatic test_p_read;
    logic [6:0] obs;
    p_req = 1; p_we = 0; p_addr = 8'h12;
    @(negedge clock);
    obs = {p_gnt, d_gnt, p_stall, mem_rden, mem_wren, p_rvalid, d_rvalid};
    vectors++;
    if (obs !== 7'b1001000 || mem_addr !== 8'h12) begin
      errors++;
      $display("FAIL p_read_issue: ctl=%b addr=%h want ctl=1001000 addr=12", obs, mem_addr);
    end
    next_cycle();
    idle_inputs();
    mem_q = 8'hC3;
    @(negedge clock);
    vectors++;
    if ({p_rvalid, d_rvalid} !== 2'b10 || rdata !== 8'hC3) begin
      errors++;
      $display("FAIL p_read_data: rv=%b rdata=%h want rv=10 rdata=c3", {p_rvalid, d_rvalid}, rdata);
    end
    next_cycle();
    @(negedge clock);
    vectors++;
    if ({p_rvalid, d_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL p_read_done: rv=%b want 00", {p_rvalid, d_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_contention;
    logic [9:0] want_d;
    logic [2:0] obs;
    want_d = 10'b1000010000;  // bit i = D wins in cycle i
    p_req = 1; p_we = 1; p_addr = 8'h01;
    d_req = 1; d_we = 1; d_addr = 8'h02;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      obs = {p_gnt, d_gnt, p_stall};
      vectors++;
      if (want_d[i]) begin
        if (obs !== 3'b011 || mem_addr !== 8'h02) begin
          errors++;
          $display("FAIL contention_cyc%0d: pgnt/dgnt/stall=%b addr=%h want 011 addr=02", i, obs, mem_addr);
        end
      end else begin
        if (obs !== 3'b100 || mem_addr !== 8'h01) begin
          errors++;
          $display("FAIL contention_cyc%0d: pgnt/dgnt/stall=%b addr=%h want 100 addr=01", i, obs, mem_addr);
        end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back;
    logic [6:0] obs;
    p_req = 1; p_we = 0; p_addr = 8'h05;
    @(negedge clock);
    vectors++;
    if ({p_gnt, mem_rden, mem_addr} !== {2'b11, 8'h05}) begin
      errors++;
      $display("FAIL b2b_p_issue: gnt=%b rden=%b addr=%h want 1 1 05", p_gnt, mem_rden, mem_addr);
    end
    next_cycle();
    idle_inputs();
    d_req = 1; d_we = 0; d_addr = 8'h06;
    mem_q = 8'h55;
    @(negedge clock);
    obs = {p_gnt, d_gnt, p_stall, mem_rden, mem_wren, p_rvalid, d_rvalid};
    vectors++;
    if (obs !== 7'b0101010 || mem_addr !== 8'h06 || rdata !== 8'h55) begin
      errors++;
      $display("FAIL b2b_cycle2: ctl=%b addr=%h rdata=%h want 0101010 06 55", obs, mem_addr, rdata);
    end
    next_cycle();
    idle_inputs();
    mem_q = 8'hAA;
    @(negedge clock);
    vectors++;
    if ({p_rvalid, d_rvalid} !== 2'b01 || rdata !== 8'hAA) begin
      errors++;
      $display("FAIL b2b_cycle3: rv=%b rdata=%h want 01 aa", {p_rvalid, d_rvalid}, rdata);
    end
    next_cycle();
  endtask

  task automatic test_lock;
    logic [2:0] obs;
    p_req = 1; p_we = 0; p_addr = 8'h80;
    d_req = 1; d_we = 1; d_lock = 1; d_addr = 8'h20; d_wdata = 8'hA0;
    // D must first starve for four cycles before it takes the memory
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if ({p_gnt, d_gnt} !== 2'b10) begin
        errors++;
        $display("FAIL lock_wait_cyc%0d: pgnt/dgnt=%b want 10", i, {p_gnt, d_gnt});
      end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      d_addr = 8'h20 + 8'(i);
      d_wdata = 8'hA0 + 8'(i);
      @(negedge clock);
      obs = {p_gnt, d_gnt, p_stall};
      vectors++;
      if (obs !== 3'b011 || mem_wren !== 1'b1 || mem_rden !== 1'b0 ||
          mem_addr !== (8'h20 + 8'(i)) || mem_wdata !== (8'hA0 + 8'(i))) begin
        errors++;
        $display("FAIL lock_write%0d: pgnt/dgnt/stall=%b wren=%b addr=%h wdata=%h want 011 1 %h %h",
                 i, obs, mem_wren, mem_addr, mem_wdata, 8'h20 + 8'(i), 8'hA0 + 8'(i));
      end
      next_cycle();
    end
    d_req = 0;
    @(negedge clock);
    obs = {p_gnt, d_gnt, p_stall};
    vectors++;
    if (obs !== 3'b001 || mem_wren !== 1'b0 || mem_rden !== 1'b0) begin
      errors++;
      $display("FAIL lock_idle_hold: pgnt/dgnt/stall=%b wren=%b rden=%b want 001 0 0", obs, mem_wren, mem_rden);
    end
    next_cycle();
    d_lock = 0;
    @(negedge clock);
    obs = {p_gnt, d_gnt, p_stall};
    vectors++;
    if (obs !== 3'b001) begin
      errors++;
      $display("FAIL lock_release_cycle: pgnt/dgnt/stall=%b want 001", obs);
    end
    next_cycle();
    @(negedge clock);
    obs = {p_gnt, d_gnt, p_stall};
    vectors++;
    if (obs !== 3'b100 || mem_addr !== 8'h80) begin
      errors++;
      $display("FAIL lock_released: pgnt/dgnt/stall=%b addr=%h want 100 80", obs, mem_addr);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid;
    d_req = 1; d_we = 0; d_addr = 8'h33; d_lock = 1;
    @(negedge clock);
    vectors++;
    if ({d_gnt, mem_rden} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_issue: dgnt/rden=%b want 11", {d_gnt, mem_rden});
    end
    next_cycle();
    d_req = 0;
    p_req = 1; p_we = 0; p_addr = 8'h44;
    @(negedge clock);
    vectors++;
    if ({d_rvalid, p_gnt, p_stall} !== 3'b101) begin
      errors++;
      $display("FAIL rst_mid_pre: drv/pgnt/stall=%b want 101", {d_rvalid, p_gnt, p_stall});
    end
    reset = 1;
    #1;
    vectors++;
    if (d_rvalid !== 1'b0 || dut.lock_own !== 1'b0 || p_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_assert: drv=%b lock=%b pgnt=%b want 0 0 1", d_rvalid, dut.lock_own, p_gnt);
    end
    next_cycle();
    d_lock = 0;
    reset = 0;
    @(negedge clock);
    vectors++;
    if ({p_gnt, p_stall, d_rvalid, p_rvalid} !== 4'b1000 || dut.starve_cnt !== 3'd0 || mem_addr !== 8'h44) begin
      errors++;
      $display("FAIL rst_mid_after: pgnt/stall/drv/prv=%b cnt=%0d addr=%h want 1000 0 44",
               {p_gnt, p_stall, d_rvalid, p_rvalid}, dut.starve_cnt, mem_addr);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_write_idle;
    logic [6:0] obs;
    p_req = 1; p_we = 1; p_addr = 8'h40; p_wdata = 8'h7F;
    @(negedge clock);
    obs = {p_gnt, d_gnt, p_stall, mem_rden, mem_wren, p_rvalid, d_rvalid};
    vectors++;
    if (obs !== 7'b1000100 || mem_addr !== 8'h40 || mem_wdata !== 8'h7F) begin
      errors++;
      $display("FAIL p_write: ctl=%b addr=%h wdata=%h want 1000100 40 7f", obs, mem_addr, mem_wdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clock);
    obs = {p_gnt, d_gnt, p_stall, mem_rden, mem_wren, p_rvalid, d_rvalid};
    vectors++;
    if (obs !== 7'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL idle_outputs: ctl=%b addr=%h wdata=%h want 0000000 00 00", obs, mem_addr, mem_wdata);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_p_read();
    test_contention();
    test_back_to_back();
    test_lock();
    test_reset_mid();
    test_write_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
